// File: rtl/ps2_host_tx_pkg.sv
// ps2_host_tx_pkg: shared PS/2 state encoding, frame geometry and default timing
package ps2_host_tx_pkg;
  typedef enum logic [2:0] {IDLE, INHIBIT, REQUEST, SHIFT, ACK, WAIT_IDLE} ps2_state_e;
  localparam int BIT_SLOTS = 10;
  localparam int DEF_CLK_HZ = 25000000;
  localparam int DEF_INHIBIT_CYCLES = 2500;
  localparam int DEF_TIMEOUT_CYCLES = 50000;
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction
endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: byte-send handshake between a client and the PS/2 host transmitter
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_err;
  modport master (output tx_data, tx_start, input tx_busy, tx_done, tx_err);
  modport slave  (input tx_data, tx_start, output tx_busy, tx_done, tx_err);
endinterface

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-FF synchronizers for the PS/2 lines plus device clock falling-edge detect
module ps2_line_sync (
  input  logic clk,
  input  logic reset_L,
  input  logic clk_in,
  input  logic data_in,
  output logic clk_sync,
  output logic data_sync,
  output logic fall_pulse
);
  logic [2:0] clk_sh_q, clk_sh_d;
  logic [1:0] data_sh_q, data_sh_d;
  always_comb begin
    clk_sh_d  = {clk_sh_q[1:0], clk_in};
    data_sh_d = {data_sh_q[0], data_in};
  end
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      clk_sh_q  <= '1;
      data_sh_q <= '1;
    end else begin
      clk_sh_q  <= clk_sh_d;
      data_sh_q <= data_sh_d;
    end
  end
  // bit 2 is the previous synced clock sample, used only for edge detection
  assign clk_sync   = clk_sh_q[1];
  assign data_sync  = data_sh_q[1];
  assign fall_pulse = clk_sh_q[2] & ~clk_sh_q[1];
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 byte transmitter (inhibit, request, shift, ack)
module ps2_host_tx import ps2_host_tx_pkg::*; #(
  parameter int CLK_HZ         = DEF_CLK_HZ,
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic           clk,
  input  logic           reset_L,
  ps2_host_tx_if.slave   bus,
  input  logic           ps2_clk_in,
  input  logic           ps2_data_in,
  output logic           ps2_clk_oe,
  output logic           ps2_data_oe
);
  localparam int CW = $clog2((TIMEOUT_CYCLES > INHIBIT_CYCLES ? TIMEOUT_CYCLES : INHIBIT_CYCLES) + 1);
  if (CLK_HZ < 1 || INHIBIT_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("ps2_host_tx: timing parameters must be positive");
  end
  ps2_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0]    frame_q, frame_d;
  logic [3:0]    idx_q, idx_d;
  logic          done_q, done_d, err_q, err_d;
  logic          clk_s, data_s, fall, timed;
  ps2_line_sync u_sync (
    .clk        (clk),
    .reset_L    (reset_L),
    .clk_in     (ps2_clk_in),
    .data_in    (ps2_data_in),
    .clk_sync   (clk_s),
    .data_sync  (data_s),
    .fall_pulse (fall)
  );
  assign timed = state_q inside {REQUEST, SHIFT, ACK, WAIT_IDLE};
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE:      if (bus.tx_start) begin
                   frame_d = {1'b1, odd_parity(bus.tx_data), bus.tx_data};
                   state_d = INHIBIT;
                 end
      INHIBIT:   state_d = cnt_q == CW'(INHIBIT_CYCLES - 1) ? REQUEST : INHIBIT;
      REQUEST:   if (fall) begin
                   idx_d   = '0;
                   state_d = SHIFT;
                 end
      SHIFT:     if (fall) begin
                   idx_d   = idx_q + 4'd1;
                   state_d = idx_q == 4'(BIT_SLOTS - 2) ? ACK : SHIFT;
                 end
      ACK:       if (fall) begin
                   err_d   = data_s;
                   state_d = data_s ? IDLE : WAIT_IDLE;
                 end
      WAIT_IDLE: if (clk_s && data_s) begin
                   done_d  = 1'b1;
                   state_d = IDLE;
                 end
      default:   state_d = IDLE;
    endcase
    // timeout only fires when nothing else moved the FSM, so done and err stay exclusive
    if (timed && !fall && state_d == state_q && cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
      err_d   = 1'b1;
      state_d = IDLE;
    end
    cnt_d = (state_q == IDLE || state_d != state_q || (timed && fall)) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      frame_q <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  assign ps2_clk_oe  = state_q == INHIBIT;
  assign ps2_data_oe = state_q == REQUEST || (state_q == SHIFT && !frame_q[idx_q]);
  assign bus.tx_busy = state_q != IDLE;
  assign bus.tx_done = done_q;
  assign bus.tx_err  = err_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench with an open-drain PS/2 device model
module tb_ps2_host_tx;
  logic clk = 1'b0;
  logic reset_L = 1'b0;
  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;
  logic ps2_clk_oe, ps2_data_oe;
  logic ps2_clk_line, ps2_data_line;
  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  ps2_host_tx_if bus();
  assign ps2_clk_line  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_line = dev_data & ~ps2_data_oe;
  ps2_host_tx dut (
    .clk         (clk),
    .reset_L     (reset_L),
    .bus         (bus.slave),
    .ps2_clk_in  (ps2_clk_line),
    .ps2_data_in (ps2_data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.tx_done === 1'b1) done_cnt++;
    if (bus.tx_err === 1'b1) err_cnt++;
    if (bus.tx_done === 1'b1 && bus.tx_err === 1'b1) both_cnt++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // device side: each slot is 40 cycles low then 40 high; host bits sampled late in the low phase
  task automatic dev_clocks(input int nfall, input bit ack, output logic [9:0] bits);
    bits = '0;
    for (int k = 0; k < nfall; k++) begin
      if (k == 10 && ack) begin
        dev_data = 1'b0;
        repeat (20) @(negedge clk);
      end
      dev_clk = 1'b0;
      repeat (40) @(negedge clk);
      if (k < 10) bits[k] = ps2_data_line;
      dev_clk = 1'b1;
      repeat (40) @(negedge clk);
    end
    dev_data = 1'b1;
  endtask
  task automatic start_tx(input logic [7:0] d, input bit inject, input string tag);
    int n = 0;
    bit dbad = 1'b0;
    bus.tx_data  = d;
    bus.tx_start = 1'b1;
    @(negedge clk);
    bus.tx_start = 1'b0;
    bus.tx_data  = ~d;
    chk({tag, " busy"}, 32'(bus.tx_busy), 32'd1);
    while (ps2_clk_oe === 1'b1 && n < 3000) begin
      dbad |= (ps2_data_oe !== 1'b0);
      bus.tx_start = inject && n == 100;
      if (inject && n == 100) bus.tx_data = 8'h00;
      @(negedge clk);
      n++;
    end
    bus.tx_start = 1'b0;
    chk({tag, " inhibit_len"}, 32'(n), 32'd2500);
    chk({tag, " inhibit_data_oe"}, 32'(dbad), 32'd0);
    chk({tag, " request_oe"}, {30'd0, ps2_clk_oe, ps2_data_oe}, 32'b01);
  endtask
  task automatic run_frame(input logic [7:0] d, input logic [9:0] exp_bits, input bit ack,
                           input bit inject, input string tag);
    int d0 = done_cnt;
    int e0 = err_cnt;
    int n = 0;
    logic [9:0] bits;
    start_tx(d, inject, tag);
    repeat (20) @(negedge clk);
    dev_clocks(11, ack, bits);
    chk({tag, " bits"}, 32'(bits), 32'(exp_bits));
    while (bus.tx_busy === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " busy_release"}, 32'(n < 100), 32'd1);
    repeat (3) @(negedge clk);
    chk({tag, " done_pulses"}, 32'(done_cnt - d0), 32'(ack));
    chk({tag, " err_pulses"}, 32'(err_cnt - e0), 32'(!ack));
    chk({tag, " lines_released"}, {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
  endtask
  initial begin
    int n;
    int d0;
    int e0;
    logic [9:0] bits;
    bus.tx_start = 1'b0;
    bus.tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {27'd0, ps2_clk_oe, ps2_data_oe, bus.tx_busy, bus.tx_done, bus.tx_err}, 32'd0);
    reset_L = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_outputs", {27'd0, ps2_clk_oe, ps2_data_oe, bus.tx_busy, bus.tx_done, bus.tx_err}, 32'd0);
    // frame words are {stop, odd parity, D7..D0}, computed by hand
    run_frame(8'hED, 10'h3ED, 1'b1, 1'b0, "ed");
    run_frame(8'hF4, 10'h2F4, 1'b1, 1'b0, "f4");
    run_frame(8'hFF, 10'h3FF, 1'b1, 1'b0, "ff");
    run_frame(8'hED, 10'h3ED, 1'b0, 1'b0, "ed_nack");
    chk("nack_busy", 32'(bus.tx_busy), 32'd0);
    run_frame(8'hED, 10'h3ED, 1'b1, 1'b1, "ed_inject");
    repeat (50) @(negedge clk);
    chk("inject_no_second_frame", {30'd0, ps2_clk_oe, bus.tx_busy}, 32'd0);
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(8'h12, 1'b0, "timeout");
    n = 0;
    while (bus.tx_err !== 1'b1 && n < 60000) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycles", 32'(n), 32'd50000);
    chk("timeout_released", {29'd0, ps2_clk_oe, ps2_data_oe, bus.tx_busy}, 32'd0);
    repeat (3) @(negedge clk);
    chk("timeout_err_pulses", 32'(err_cnt - e0), 32'd1);
    chk("timeout_done_pulses", 32'(done_cnt - d0), 32'd0);
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(8'hA5, 1'b0, "rst_mid");
    repeat (20) @(negedge clk);
    dev_clocks(5, 1'b0, bits);
    chk("rst_mid_d4_driven", 32'(ps2_data_oe), 32'd1);
    #1 reset_L = 1'b0;
    #1 chk("rst_mid_async", {27'd0, ps2_clk_oe, ps2_data_oe, bus.tx_busy, bus.tx_done, bus.tx_err}, 32'd0);
    repeat (3) @(negedge clk);
    reset_L = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_mid_no_pulses", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
    run_frame(8'hAA, 10'h3AA, 1'b1, 1'b0, "aa_after_rst");
    chk("done_err_exclusive", 32'(both_cnt), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter CLK_HZ, default 25000000, system clock frequency.
REQ-002 Parameter INHIBIT_CYCLES, default 2500, clock-low hold time before the request (100 us at 25 MHz).
REQ-003 Parameter TIMEOUT_CYCLES, default 50000, maximum wait for any device clock edge (2 ms at 25 MHz).
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 reset_L  input  1  asynchronous, active-low reset.
REQ-006 tx_data  input  8  byte to send to the PS/2 device.
REQ-007 tx_start  input  1  one-cycle request; accepted only when tx_busy=0.
REQ-008 tx_busy  output  1  high from the cycle after acceptance until done or error.
REQ-009 tx_done  output  1  one-cycle pulse: device ACK received and lines idle.
REQ-010 tx_err  output  1  one-cycle pulse: no ACK or timeout.
REQ-011 ps2_clk_in / ps2_data_in  input  1 each  raw open-drain line levels.
REQ-012 ps2_clk_oe / ps2_data_oe  output  1 each  1 = drive line low, 0 = release (pulled high).

Function
REQ-013 ps2_clk_in and ps2_data_in SHALL pass through 2-FF synchronizers; falling edge of the synced clock SHALL be a one-cycle fall_pulse.
REQ-014 States SHALL be IDLE, INHIBIT, REQUEST, SHIFT, ACK, WAIT_IDLE.
REQ-015 IDLE: both oe=0; on tx_start latch tx_data, compute odd parity (~^tx_data), go INHIBIT.
REQ-016 INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles; ps2_data_oe=0; then REQUEST.
REQ-017 REQUEST: ps2_data_oe=1 (start bit 0), ps2_clk_oe=0; on the first fall_pulse go SHIFT with bit index 0.
REQ-018 SHIFT: on each fall_pulse drive the next bit (ps2_data_oe = ~bit): D0..D7 LSB first, then parity, then stop (oe=0); after the stop bit is driven go ACK.
REQ-019 ACK: on the next fall_pulse sample synced data; 0 -> WAIT_IDLE, 1 -> tx_err pulse, IDLE.
REQ-020 WAIT_IDLE: when synced clk and data both high, pulse tx_done, go IDLE.
REQ-021 A cycle counter SHALL reset on every fall_pulse and state change; reaching TIMEOUT_CYCLES in REQUEST, SHIFT, ACK or WAIT_IDLE SHALL release both lines, pulse tx_err, go IDLE.
REQ-022 tx_start while tx_busy=1 SHALL be ignored; tx_data changes after acceptance SHALL not affect the frame.
REQ-023 tx_done and tx_err SHALL never assert in the same cycle.
REQ-024 Exactly 11 falling device edges SHALL be consumed per successful frame (10 bit slots + ACK).

Reset
REQ-025 reset_L=0 SHALL immediately (asynchronously) force ps2_clk_oe=0, ps2_data_oe=0, tx_busy=0, tx_done=0, tx_err=0, state IDLE, counters 0, synchronizers to 1.
REQ-026 Reset mid-frame SHALL release both lines with no error pulse; first tx_start after deassertion starts a fresh frame.

Structure
REQ-027 A shared ps2 package/include SHALL hold the state encoding, bit-slot count (10) and default timing constants; ps2 receive logic SHALL reuse it.
REQ-028 One sub-module ps2_line_sync SHALL contain the two synchronizers and the falling-edge detector.

Verification
REQ-029 tx_data=0xED, device model ACKs -> clk held low 2500 cycles, bits 1,0,1,1,0,1,1,1, parity 1, stop 1, tx_done pulse once, tx_err 0.
REQ-030 tx_data=0xF4 -> parity slot 0; tx_data=0xFF -> parity slot 1; both complete with tx_done.
REQ-031 Device holds data high at ACK edge -> tx_err pulse, both oe=0, state IDLE, no tx_done.
REQ-032 Device never clocks after REQUEST -> tx_err exactly 50000 cycles after entering REQUEST, lines released.
REQ-033 Second tx_start=0x00 during an 0xED frame -> ignored; only 0xED appears on the line.
REQ-034 reset_L pulsed low after bit 4 -> both oe=0 same cycle, no pulses; next tx_start 0xAA sends a correct full frame.
